// File: rtl/key_expand_multi.sv
// Word-serial AES key expansion for 128/192/256-bit keys with a combinational round-key read port.
// Optional feature: define KEY_EXPAND_INV_EN to add the equivalent-inverse-cipher (InvMixColumns) read path.
//
// state      | meaning
// -----------+------------------------------------------------
// ST_IDLE    | no valid schedule, waiting for start
// ST_LOAD    | capturing Nk cipher-key words, one per cycle
// ST_EXPAND  | generating w[Nk .. 4*Nr+3], one word per step
// ST_DONE    | schedule complete and readable
module key_expand_multi #(
    parameter int MAX_NK    = 8,
    parameter int SBOX_PIPE = 0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [1:0]  key_len,
    input  logic [31:0] cipher_key,
    input  logic [3:0]  round_key_num,
    input  logic [1:0]  r_index,
    input  logic        inv_sel,
    output logic [31:0] round_key,
    output logic        done,
    output logic        busy,
    output logic        key_err
);

    localparam int DEPTH = 4 * (MAX_NK + 7);

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_EXPAND, ST_DONE} state_t;

    state_t      state, state_next;
    logic [1:0]  len_q;
    logic [5:0]  cnt;
    logic [2:0]  j;
    logic [7:0]  rcon;
    logic        phase;
    logic [31:0] temp_q;
    logic [31:0] w [DEPTH];

    logic [3:0]  nk, nr;
    logic [5:0]  last_idx, prev_idx, old_idx, rd_idx;
    logic        legal, word_wr, wr_en;
    logic [31:0] prev_word, temp_comb, temp_use, wr_data, rd_word;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = '0;
        x = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254, followed by the AES affine transform.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] sq, inv;
        sq  = x;
        inv = 8'h01;
        for (int k = 1; k < 8; k++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] a);
        return {sbox(a[31:24]), sbox(a[23:16]), sbox(a[15:8]), sbox(a[7:0])};
    endfunction

    function automatic logic [3:0] nk_of(input logic [1:0] len);
        case (len)
            2'd0:    return 4'd4;
            2'd1:    return 4'd6;
            2'd2:    return 4'd8;
            default: return 4'd0;
        endcase
    endfunction

    assign legal    = (key_len != 2'd3) && (int'(nk_of(key_len)) <= MAX_NK);
    assign nk       = nk_of(len_q);
    assign nr       = nk + 4'd6;
    assign last_idx = {nr, 2'b11};
    assign prev_idx = cnt - 6'd1;
    assign old_idx  = cnt - {2'b00, nk};
    assign word_wr  = (state == ST_EXPAND) && ((SBOX_PIPE == 0) || phase);

    // j tracks i mod Nk so no divider is needed.
    always_comb begin
        prev_word = w[prev_idx];
        temp_comb = prev_word;
        if (j == 3'd0)
            temp_comb = sub_word({prev_word[23:0], prev_word[31:24]}) ^ {rcon, 24'h0};
        else if (nk == 4'd8 && j == 3'd4)
            temp_comb = sub_word(prev_word);
    end

    assign temp_use = (SBOX_PIPE != 0) ? temp_q : temp_comb;
    assign wr_en    = !start && ((state == ST_LOAD) || word_wr);
    assign wr_data  = (state == ST_LOAD) ? cipher_key : (w[old_idx] ^ temp_use);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        done       = 1'b0;
        busy       = 1'b0;
        case (state)
            ST_LOAD:   busy = 1'b1;
            ST_EXPAND: busy = 1'b1;
            ST_DONE:   done = 1'b1;
            default:   ;
        endcase
        if (start) begin
            state_next = legal ? ST_LOAD : ST_IDLE;
        end else begin
            case (state)
                ST_LOAD:   if (cnt == {2'b00, nk} - 6'd1) state_next = ST_EXPAND;
                ST_EXPAND: if (word_wr && cnt == last_idx) state_next = ST_DONE;
                default:   ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            len_q   <= 2'd0;
            cnt     <= '0;
            j       <= '0;
            rcon    <= 8'h01;
            phase   <= 1'b0;
            temp_q  <= '0;
            key_err <= 1'b0;
        end else if (start) begin
            len_q   <= key_len;
            key_err <= !legal;
            cnt     <= '0;
            j       <= '0;
            rcon    <= 8'h01;
            phase   <= 1'b0;
        end else if (state == ST_LOAD) begin
            cnt <= cnt + 6'd1;
        end else if (state == ST_EXPAND) begin
            if (!word_wr) begin
                temp_q <= temp_comb;
                phase  <= 1'b1;
            end else begin
                cnt   <= cnt + 6'd1;
                phase <= 1'b0;
                j     <= ({1'b0, j} == nk - 4'd1) ? 3'd0 : j + 3'd1;
                if (j == 3'd0) rcon <= xtime(rcon);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < DEPTH; k++) w[k] <= '0;
        end else if (wr_en) begin
            w[cnt] <= wr_data;
        end
    end

    assign rd_idx  = {round_key_num, r_index};
    assign rd_word = (done && round_key_num <= nr && int'(rd_idx) < DEPTH) ? w[rd_idx] : 32'h0;

`ifdef KEY_EXPAND_INV_EN
    function automatic logic [31:0] inv_mix(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = c;
        return {gf_mul(8'h0e, a0) ^ gf_mul(8'h0b, a1) ^ gf_mul(8'h0d, a2) ^ gf_mul(8'h09, a3),
                gf_mul(8'h09, a0) ^ gf_mul(8'h0e, a1) ^ gf_mul(8'h0b, a2) ^ gf_mul(8'h0d, a3),
                gf_mul(8'h0d, a0) ^ gf_mul(8'h09, a1) ^ gf_mul(8'h0e, a2) ^ gf_mul(8'h0b, a3),
                gf_mul(8'h0b, a0) ^ gf_mul(8'h0d, a1) ^ gf_mul(8'h09, a2) ^ gf_mul(8'h0e, a3)};
    endfunction

    assign round_key = (inv_sel && round_key_num != 4'd0 && round_key_num < nr)
                     ? inv_mix(rd_word) : rd_word;
`else
    logic unused_inv;
    assign unused_inv = inv_sel;
    assign round_key  = rd_word;
`endif

endmodule

// File: tb/tb_key_expand_multi.sv
// Self-checking bench for key_expand_multi: published vectors plus random keys against a FIPS-197 model.
// Define KEY_EXPAND_INV_EN for both files to also exercise the inverse-form read path.
module tb_key_expand_multi;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  key_len = 2'd0;
    logic [31:0] cipher_key = '0;
    logic [3:0]  round_key_num = '0;
    logic [1:0]  r_index = '0;
    logic        inv_sel = 1'b0;
    logic [31:0] round_key;
    logic        done, busy, key_err;

    int checks = 0;
    int errors = 0;

    logic [7:0]  sbox_t [256];
    logic [31:0] model_w [60];
    logic [31:0] key_buf [8];

    key_expand_multi dut (
        .clk(clk), .reset_n(reset_n), .start(start), .key_len(key_len),
        .cipher_key(cipher_key), .round_key_num(round_key_num), .r_index(r_index),
        .inv_sel(inv_sel), .round_key(round_key), .done(done), .busy(busy), .key_err(key_err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        int p = 0;
        int x = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ x;
            x = x << 1;
            if (x > 255) x = x ^ 'h11b;
        end
        return 8'(p);
    endfunction

    task automatic build_sbox();
        logic [7:0] c = 8'h63;
        for (int x = 0; x < 256; x++) begin
            logic [7:0] b = 8'h00;
            logic [7:0] s;
            for (int y = 1; y < 256 && x != 0; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) b = 8'(y);
            for (int i = 0; i < 8; i++)
                s[i] = b[i] ^ b[(i + 4) % 8] ^ b[(i + 5) % 8] ^ b[(i + 6) % 8] ^ b[(i + 7) % 8] ^ c[i];
            sbox_t[x] = s;
        end
    endtask

    function automatic logic [31:0] sub_w(input logic [31:0] a);
        return {sbox_t[a[31:24]], sbox_t[a[23:16]], sbox_t[a[15:8]], sbox_t[a[7:0]]};
    endfunction

    function automatic logic [31:0] inv_mix_m(input logic [31:0] c);
        logic [7:0] a [4];
        logic [7:0] m [4] = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
        logic [31:0] r = '0;
        for (int k = 0; k < 4; k++) a[k] = c[31 - 8 * k -: 8];
        for (int row = 0; row < 4; row++) begin
            logic [7:0] v = 8'h00;
            for (int col = 0; col < 4; col++) v = v ^ gmul(m[(col - row + 4) % 4], a[col]);
            r[31 - 8 * row -: 8] = v;
        end
        return r;
    endfunction

    // Straight FIPS-197 expansion with explicit i mod Nk and i/Nk.
    task automatic model_expand(input int nk);
        logic [7:0] rc [11] = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
        int nr = nk + 6;
        for (int k = 0; k < 60; k++) model_w[k] = '0;
        for (int k = 0; k < nk; k++) model_w[k] = key_buf[k];
        for (int i = nk; i <= 4 * nr + 3; i++) begin
            logic [31:0] t = model_w[i - 1];
            if (i % nk == 0)
                t = sub_w({t[23:0], t[31:24]}) ^ {rc[i / nk], 24'h0};
            else if (nk == 8 && i % 8 == 4)
                t = sub_w(t);
            model_w[i] = model_w[i - nk] ^ t;
        end
    endtask

    // lat counts clock edges including the start edge.
    task automatic start_load(input int len, output int lat);
        @(negedge clk);
        start   = 1'b1;
        key_len = 2'(len);
        @(posedge clk);
        lat = 1;
        for (int n = 0; n < 4 + 2 * len; n++) begin
            @(negedge clk);
            start      = 1'b0;
            key_len    = 2'($urandom_range(0, 3));
            cipher_key = key_buf[n];
            @(posedge clk);
            lat++;
        end
        @(negedge clk);
        cipher_key = $urandom;
    endtask

    task automatic wait_done(inout int lat);
        while (!done && lat < 300) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        if (!done) check_eq("done_timeout", 32'(done), 32'd1);
    endtask

    task automatic run_key(input int len, output int lat);
        start_load(len, lat);
        wait_done(lat);
    endtask

    task automatic check_round(input int r, input int nr);
        for (int q = 0; q < 4; q++) begin
            round_key_num = 4'(r);
            r_index       = 2'(q);
            #1;
            check_eq($sformatf("rd_r%0d_w%0d", r, q), round_key, (r <= nr) ? model_w[4 * r + q] : 32'h0);
        end
    endtask

    task automatic check_vec(input string tag, input int r, input logic [127:0] v);
        for (int q = 0; q < 4; q++) begin
            round_key_num = 4'(r);
            r_index       = 2'(q);
            #1;
            check_eq($sformatf("%s_w%0d", tag, q), round_key, v[127 - 32 * q -: 32]);
        end
    endtask

    task automatic set_key(input logic [255:0] k, input int nk);
        for (int n = 0; n < 8; n++) key_buf[n] = (n < nk) ? k[255 - 32 * n -: 32] : 32'h0;
    endtask

    localparam logic [255:0] KEY1 = {128'h5468617473206D79204B756E67204675, 128'h0};
    localparam logic [255:0] KEY2 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [255:0] KEY3 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
    localparam logic [255:0] KEY4 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    localparam logic [127:0] R1 = 128'h28fddef86da4244accc0a4fe3b316f26;
    localparam logic [127:0] R2 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] R3 = 128'he98ba06f448c773c8ecc720401002202;
    localparam logic [127:0] R4 = 128'hfe4890d1e6188d0b046df344706c631e;

    initial begin
        int lat;
        build_sbox();
        #2 reset_n = 1'b0;
        #20;
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_key_err", 32'(key_err), 32'd0);
        check_eq("rst_read", round_key, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;

        set_key(KEY1, 4); model_expand(4);
        run_key(0, lat);
        check_eq("lat128", 32'(lat), 32'd45);
        check_vec("t1_r10", 10, R1);
        check_round(0, 10);

        set_key(KEY2, 4); model_expand(4);
        run_key(0, lat);
        check_vec("t2_r10", 10, R2);

        set_key(KEY3, 6); model_expand(6);
        run_key(1, lat);
        check_eq("lat192", 32'(lat), 32'd53);
        check_vec("t3_r12", 12, R3);
        check_round(13, 12);

        set_key(KEY4, 8); model_expand(8);
        run_key(2, lat);
        check_eq("lat256", 32'(lat), 32'd61);
        check_vec("t4_r14", 14, R4);
        check_round(15, 14);

        repeat (6) begin
            int len = $urandom_range(0, 2);
            int nk  = 4 + 2 * len;
            for (int n = 0; n < 8; n++) key_buf[n] = $urandom;
            model_expand(nk);
            run_key(len, lat);
            check_eq("lat_rand", 32'(lat), 32'(1 + 4 * (nk + 7)));
            for (int r = 0; r <= nk + 6; r++) check_round(r, nk + 6);
            check_round(nk + 7, nk + 6);
        end

        // Restart a 256-bit run mid-expansion with a 128-bit key.
        set_key(KEY4, 8);
        start_load(2, lat);
        repeat (12) @(posedge clk);
        @(negedge clk);
        check_eq("abort_busy", 32'(busy), 32'd1);
        check_eq("abort_done", 32'(done), 32'd0);
        round_key_num = 4'd0; r_index = 2'd0; #1;
        check_eq("abort_read", round_key, 32'h0);
        set_key(KEY2, 4); model_expand(4);
        run_key(0, lat);
        check_eq("restart_lat", 32'(lat), 32'd45);
        check_vec("t5_r10", 10, R2);

        @(negedge clk);
        start = 1'b1; key_len = 2'd3;
        @(negedge clk);
        start = 1'b0; key_len = 2'd0;
        repeat (3) @(negedge clk);
        check_eq("ill_key_err", 32'(key_err), 32'd1);
        check_eq("ill_done", 32'(done), 32'd0);
        check_eq("ill_busy", 32'(busy), 32'd0);
        check_round(0, -1);

        // Asynchronous reset in the middle of expansion.
        set_key(KEY1, 4); model_expand(4);
        start_load(0, lat);
        check_eq("legal_clears_err", 32'(key_err), 32'd0);
        repeat (10) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check_eq("mid_rst_done", 32'(done), 32'd0);
        check_eq("mid_rst_busy", 32'(busy), 32'd0);
        check_round(0, -1);
        check_round(10, -1);
        @(negedge clk);
        reset_n = 1'b1;
        run_key(0, lat);
        check_eq("post_rst_lat", 32'(lat), 32'd45);
        check_vec("t6_r10", 10, R1);

`ifdef KEY_EXPAND_INV_EN
        inv_sel = 1'b1;
        check_round(0, 10);
        check_round(10, 10);
        for (int q = 0; q < 4; q++) begin
            round_key_num = 4'd5;
            r_index       = 2'(q);
            #1;
            check_eq($sformatf("inv_r5_w%0d", q), round_key, inv_mix_m(model_w[20 + q]));
        end
        inv_sel = 1'b0;
`else
        inv_sel = 1'b1;
        check_round(5, 10);
        inv_sel = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
